// File: rtl/fft8_pkg.sv
// Shared definitions for the 8-point FFT datapath: default sizes, the
// fixed-point field layout of a sample word, and the bit-reversal helper
// used to reorder a frame for decimation-in-time butterflies.
package fft8_pkg;

    // Default sample word width and frame length.
    localparam int DW_DEF = 16;
    localparam int N_DEF  = 8;

    // Sample word layout, bit 0 = MSB: [0:2] integer field, [3:DW-1] fraction.
    localparam int INT_MSB  = 0;
    localparam int INT_LSB  = 2;
    localparam int FRAC_MSB = 3;

    // Widest address the helper handles (N up to 16).
    localparam int ADDR_MAX_W = 4;

    // Reverse the low 'logn' bits of addr; bits at and above logn come back 0.
    function automatic logic [ADDR_MAX_W-1:0] bitrev(input logic [ADDR_MAX_W-1:0] addr,
                                                     input int logn);
        logic [ADDR_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < ADDR_MAX_W; i++) begin
            for (int j = 0; j < ADDR_MAX_W; j++) begin
                if ((i < logn) && (j == logn - 1 - i)) begin
                    r[i] = addr[j];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft8_pp_bank.sv
// Two-bank (ping-pong) sample store. One bank is written while the other is
// read; each bank carries a full flag that is set when the writer commits a
// frame into it and cleared when the reader has fetched its last word.
module fft8_pp_bank
    import fft8_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int N  = N_DEF,
    localparam int LOGN = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    // write port
    input  logic            we,
    input  logic            wbank,
    input  logic [LOGN-1:0] waddr,
    input  logic [0:DW-1]   wre,
    input  logic [0:DW-1]   wim,
    input  logic            set_full,
    // read port
    input  logic            rbank,
    input  logic [LOGN-1:0] raddr,
    input  logic            clr_full,
    output logic [0:DW-1]   rre,
    output logic [0:DW-1]   rim,
    // bank status
    output logic [1:0]      full
);

    logic [0:DW-1] mem_re [2][N];
    logic [0:DW-1] mem_im [2][N];
    logic [1:0]    full_nxt;

    // Next full flags; the writer and reader never target the same bank on
    // one edge (set needs the bank empty, clear needs it full), so both apply.
    always_comb begin
        full_nxt = full;
        if (clr_full) begin
            full_nxt[rbank] = 1'b0;
        end
        if (set_full) begin
            full_nxt[wbank] = 1'b1;
        end
    end

    // Full flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= '0;
        end else begin
            full <= full_nxt;
        end
    end

    // Sample storage; cleared on reset so no stale frame survives it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int a = 0; a < N; a++) begin
                    mem_re[b][a] <= '0;
                    mem_im[b][a] <= '0;
                end
            end
        end else if (we) begin
            mem_re[wbank][waddr] <= wre;
            mem_im[wbank][waddr] <= wim;
        end
    end

    // Asynchronous read; the top level registers the selected word.
    assign rre = mem_re[rbank][raddr];
    assign rim = mem_im[rbank][raddr];

endmodule

// File: rtl/fft8_bitrev_loader.sv
// FFT input stage: accepts complex samples in natural order, stores each one
// at its bit-reversed address, and streams whole frames out sequentially so
// the butterfly stage sees decimation-in-time order. Ping-pong banking lets a
// new frame load while the previous frame drains.
module fft8_bitrev_loader
    import fft8_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int N  = N_DEF,
    localparam int LOGN = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    // input stream, natural order
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [0:DW-1]   in_re,
    input  logic [0:DW-1]   in_im,
    input  logic            in_last,
    // output stream, bit-reversed order
    output logic            out_valid,
    input  logic            out_ready,
    output logic [0:DW-1]   out_re,
    output logic [0:DW-1]   out_im,
    output logic [LOGN-1:0] out_idx,
    output logic            out_last,
    // framing violation pulse
    output logic            frame_err
);

    logic [LOGN-1:0] wcnt;
    logic [LOGN-1:0] rcnt;
    logic            wbank;
    logic            rbank;
    logic [1:0]      full;

    logic            accept;
    logic            wlast;
    logic            commit;
    logic [LOGN-1:0] waddr;
    logic            adv;
    logic            load;
    logic            rlast;
    logic [0:DW-1]   rd_re;
    logic [0:DW-1]   rd_im;

    // Write-side handshake. in_ready is held low while reset is asserted so
    // every output reads 0 during reset.
    assign in_ready = ~rst & ~full[wbank];
    assign accept   = in_valid & in_ready;
    assign wlast    = (wcnt == LOGN'(N - 1));
    // A frame commits on its N-th sample whether or not in_last was present.
    assign commit   = accept & wlast;
    assign waddr    = LOGN'(bitrev(ADDR_MAX_W'(wcnt), LOGN));

    // Read side: fetch a new word whenever the output register is empty or
    // being consumed, as long as the read bank holds a complete frame.
    assign adv   = ~out_valid | out_ready;
    assign load  = adv & full[rbank];
    assign rlast = (rcnt == LOGN'(N - 1));

    fft8_pp_bank #(
        .DW (DW),
        .N  (N)
    ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .we       (accept),
        .wbank    (wbank),
        .waddr    (waddr),
        .wre      (in_re),
        .wim      (in_im),
        .set_full (commit),
        .rbank    (rbank),
        .raddr    (rcnt),
        .clr_full (load & rlast),
        .rre      (rd_re),
        .rim      (rd_im),
        .full     (full)
    );

    // Write counter, bank toggle and framing check. An early in_last drops
    // the partial frame: the counter restarts and the bank is reused.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt      <= '0;
            wbank     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= accept & (in_last ^ wlast);
            if (accept) begin
                if (wlast || in_last) begin
                    wcnt <= '0;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
                if (wlast) begin
                    wbank <= ~wbank;
                end
            end
        end
    end

    // Output register and read counter; contents hold while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt      <= '0;
            rbank     <= 1'b0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else if (adv) begin
            if (full[rbank]) begin
                out_valid <= 1'b1;
                out_re    <= rd_re;
                out_im    <= rd_im;
                out_idx   <= rcnt;
                out_last  <= rlast;
                if (rlast) begin
                    rcnt  <= '0;
                    rbank <= ~rbank;
                end else begin
                    rcnt  <= rcnt + 1'b1;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // The load strobe is only meaningful for the bank release.
    logic unused_load;
    assign unused_load = load;

endmodule

// File: tb/tb_fft8_bitrev_loader.sv
// Directed bench for fft8_bitrev_loader: a vector table for the basic frame,
// then hand-written sequences for back-pressure, stalls, framing errors,
// asynchronous reset and sustained throughput.
`timescale 1ns/1ps
module tb_fft8_bitrev_loader;

    localparam int DW   = 16;
    localparam int N    = 8;
    localparam int LOGN = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [0:DW-1]   in_re;
    logic [0:DW-1]   in_im;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [0:DW-1]   out_re;
    logic [0:DW-1]   out_im;
    logic [LOGN-1:0] out_idx;
    logic            out_last;
    logic            frame_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fft8_bitrev_loader #(.DW(DW), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .frame_err (frame_err)
    );

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        logic [2:0]  idx;
        logic        last;
    } cap_t;

    typedef struct {
        logic [15:0] k;
        logic        in_l;
        logic [2:0]  idx;
        logic [15:0] re;
        logic [15:0] im;
        logic        last;
    } vec_t;

    cap_t cap[$];
    cap_t held;
    vec_t vec[8];
    int   br[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int   ferr_cnt = 0;
    int   stall_checks = 0;
    logic stall_prev = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Output monitor on the falling edge: captures transfers, counts
    // frame_err pulses and checks that stalled outputs hold.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                stall_checks++;
                chk("stall_valid", int'(out_valid), 1);
                chk("stall_re",  int'(out_re),  int'(held.re));
                chk("stall_im",  int'(out_im),  int'(held.im));
                chk("stall_idx", int'(out_idx), int'(held.idx));
            end
            if (frame_err) ferr_cnt++;
            if (out_valid && out_ready) cap.push_back('{out_re, out_im, out_idx, out_last});
            stall_prev = out_valid && !out_ready;
            held = '{out_re, out_im, out_idx, out_last};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer n samples re = base+k, im = 0x100+base+k; in_last at last_pos.
    task automatic send(input int base, input int n, input int last_pos);
        int budget;
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_re    = 16'(base + k);
            in_im    = 16'(16'h0100 + base + k);
            in_last  = (k == last_pos);
            budget   = 0;
            while (!in_ready && budget < 200) begin
                step();
                budget++;
            end
            if (!in_ready) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: sample %0d of base 0x%0h not accepted", k, base);
                break;
            end
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Run with out_ready=1 until n words are captured (bounded), then confirm
    // no extra words follow.
    task automatic drain(input int n);
        int budget;
        out_ready = 1'b1;
        budget = 0;
        while (cap.size() < n && budget < 300) begin
            step();
            budget++;
        end
        repeat (10) step();
        chk("drain_count", cap.size(), n);
    endtask

    // Compare captured words with nfr bit-reversed frames built from base.
    task automatic check_frames(input int nfr, input int base);
        int lim;
        int f;
        int p;
        int e;
        lim = (cap.size() < nfr * 8) ? cap.size() : nfr * 8;
        for (int j = 0; j < lim; j++) begin
            f = j / 8;
            p = j % 8;
            e = (base + f * 8 + br[p]) & 16'hffff;
            chk($sformatf("w%0d_re", j),   int'(cap[j].re),   e);
            chk($sformatf("w%0d_im", j),   int'(cap[j].im),   (16'h0100 + e) & 16'hffff);
            chk($sformatf("w%0d_idx", j),  int'(cap[j].idx),  p);
            chk($sformatf("w%0d_last", j), int'(cap[j].last), (p == 7) ? 1 : 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        int sc0;
        int first;
        int vcnt;
        int lastv;

        vec[0] = '{16'd0, 1'b0, 3'd0, 16'h0000, 16'h0100, 1'b0};
        vec[1] = '{16'd1, 1'b0, 3'd1, 16'h0004, 16'h0104, 1'b0};
        vec[2] = '{16'd2, 1'b0, 3'd2, 16'h0002, 16'h0102, 1'b0};
        vec[3] = '{16'd3, 1'b0, 3'd3, 16'h0006, 16'h0106, 1'b0};
        vec[4] = '{16'd4, 1'b0, 3'd4, 16'h0001, 16'h0101, 1'b0};
        vec[5] = '{16'd5, 1'b0, 3'd5, 16'h0005, 16'h0105, 1'b0};
        vec[6] = '{16'd6, 1'b0, 3'd6, 16'h0003, 16'h0103, 1'b0};
        vec[7] = '{16'd7, 1'b1, 3'd7, 16'h0007, 16'h0107, 1'b1};

        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_re = '0;
        in_im = '0;
        out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready",  int'(in_ready),  0);
        chk("rst_out_re",    int'(out_re),    0);
        chk("rst_out_im",    int'(out_im),    0);
        chk("rst_out_idx",   int'(out_idx),   0);
        chk("rst_out_last",  int'(out_last),  0);
        chk("rst_frame_err", int'(frame_err), 0);
        #1 rst = 1'b0;
        #1;
        chk("rel_in_ready", int'(in_ready), 1);
        step();

        // Test 1: one frame from the vector table
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_re    = vec[i].k;
            in_im    = 16'h0100 + vec[i].k;
            in_last  = vec[i].in_l;
            chk("t1_in_ready", int'(in_ready), 1);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("t1_lat_gap", int'(out_valid), 0);
        step();
        chk("t1_lat_first", int'(out_valid), 1);
        drain(8);
        for (int i = 0; i < 8 && i < cap.size(); i++) begin
            chk($sformatf("t1_re%0d", i),   int'(cap[i].re),   int'(vec[i].re));
            chk($sformatf("t1_im%0d", i),   int'(cap[i].im),   int'(vec[i].im));
            chk($sformatf("t1_idx%0d", i),  int'(cap[i].idx),  int'(vec[i].idx));
            chk($sformatf("t1_last%0d", i), int'(cap[i].last), int'(vec[i].last));
        end
        chk("t1_frame_err", ferr_cnt, 0);
        cap.delete();

        // Test 2: back-pressure with three frames offered
        out_ready = 1'b0;
        send(16'h10, 8, 7);
        send(16'h18, 8, 7);
        chk("t2_ready_low", int'(in_ready), 0);
        in_valid = 1'b1;
        in_re    = 16'h20;
        in_im    = 16'h0120;
        in_last  = 1'b0;
        repeat (4) begin
            step();
            chk("t2_ready_held", int'(in_ready), 0);
        end
        chk("t2_no_output", cap.size(), 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        send(16'h20, 8, 7);
        drain(24);
        check_frames(3, 16'h10);
        cap.delete();

        // Test 3: out_ready toggling every cycle during readout
        out_ready = 1'b0;
        send(16'h40, 8, 7);
        sc0 = stall_checks;
        for (int c = 0; c < 40; c++) begin
            out_ready = (c % 2 == 1);
            step();
        end
        drain(8);
        check_frames(1, 16'h40);
        chk("t3_stalls_seen", (stall_checks - sc0 >= 4) ? 1 : 0, 1);
        cap.delete();

        // Test 4: early in_last discards the partial frame
        out_ready = 1'b1;
        f0 = ferr_cnt;
        send(16'h50, 5, 4);
        chk("t4_err_pulse", int'(frame_err), 1);
        step();
        chk("t4_err_clear", int'(frame_err), 0);
        repeat (10) step();
        chk("t4_no_output", cap.size(), 0);
        send(16'h60, 8, 7);
        drain(8);
        check_frames(1, 16'h60);
        chk("t4_err_count", ferr_cnt - f0, 1);
        cap.delete();

        // Test 5: asynchronous reset mid-readout and mid-load
        out_ready = 1'b0;
        send(16'h70, 8, 7);
        send(16'h80, 4, -1);
        chk("t5_idx0", int'(out_idx), 0);
        out_ready = 1'b1;
        repeat (3) step();
        out_ready = 1'b0;
        chk("t5_valid_pre", int'(out_valid), 1);
        chk("t5_idx3", int'(out_idx), 3);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_valid", int'(out_valid), 0);
        chk("t5_rst_ready", int'(in_ready),  0);
        chk("t5_rst_re",    int'(out_re),    0);
        chk("t5_rst_im",    int'(out_im),    0);
        chk("t5_rst_idx",   int'(out_idx),   0);
        chk("t5_rst_last",  int'(out_last),  0);
        cap.delete();
        #10 rst = 1'b0;
        step();
        out_ready = 1'b1;
        repeat (10) step();
        chk("t5_no_residual", cap.size(), 0);
        chk("t5_valid_idle", int'(out_valid), 0);
        send(16'h90, 8, 7);
        drain(8);
        check_frames(1, 16'h90);
        cap.delete();

        // Test 6: five back-to-back frames at full rate
        out_ready = 1'b1;
        first = -1;
        vcnt = 0;
        lastv = -1;
        for (int c = 0; c < 60; c++) begin
            if (c < 40) begin
                in_valid = 1'b1;
                in_re    = 16'(c);
                in_im    = 16'(16'h0100 + c);
                in_last  = (c % 8 == 7);
                chk("t6_in_ready", int'(in_ready), 1);
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            step();
            if (out_valid) begin
                if (first < 0) first = c;
                vcnt++;
                lastv = c;
            end
        end
        chk("t6_first_valid", first, 8);
        chk("t6_valid_count", vcnt, 40);
        chk("t6_last_valid", lastv, 47);
        chk("t6_words", cap.size(), 40);
        check_frames(5, 0);
        chk("t6_frame_err", ferr_cnt - f0, 1);
        cap.delete();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
